// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host transmit path.
//   * FSM state encoding for ps2_host_tx (plain localparams so older tools
//     and waveform scripts that match on numeric values keep working).
//   * Keyboard command / response byte constants.
//   * Odd-parity helper used to build the frame.
package ps2_pkg;

  // Transmit FSM states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Keyboard commands and the device acknowledge byte
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Index of the stop bit in the 11-bit frame {stop, parity, data[7:0], start}
  localparam logic [3:0] LAST_BIT     = 4'd10;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter -- conditions one asynchronous PS/2 pad input.
//   Two-flop synchroniser, then a stable-count filter: the filtered value only
//   follows the synced value after it has differed for FILTER_LEN consecutive
//   cycles, so short glitches on the cable never reach the FSM.
// Ports:
//   clk_50MHz  in   system clock
//   rst        in   asynchronous reset, active-high (line idles high)
//   pad        in   raw pad input
//   filt       out  filtered line level
//   fall       out  1-cycle strobe, asserted in the cycle filt becomes 0
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic pad,
  output logic filt,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          meta_r;
  logic          sync_r;
  logic          filt_r;
  logic          fall_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchroniser; resets to the idle (released, high) level
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= pad;
      sync_r <= meta_r;
    end
  end

  // Stable-count filter and falling-edge strobe
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      filt_r <= 1'b1;
      cnt_r  <= '0;
      fall_r <= 1'b0;
    end else if (sync_r != filt_r) begin
      if (cnt_r == CNT_LAST) begin
        filt_r <= sync_r;
        cnt_r  <= '0;
        // filt_r still holds the old level: 1 here means a 1 -> 0 change
        fall_r <= filt_r;
      end else begin
        cnt_r  <= cnt_r + CNT_ONE;
        fall_r <= 1'b0;
      end
    end else begin
      cnt_r  <= '0;
      fall_r <= 1'b0;
    end
  end

  assign filt = filt_r;
  assign fall = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter (send side of the keyboard link).
//   Sends one command byte: inhibit the clock, request-to-send (start bit),
//   shift data/parity/stop on device-generated clock falls, then check the
//   device ACK. The block only ever pulls lines low; the pad layer turns
//   *_low = 1 into a driven 0 and *_low = 0 into high-Z.
// Ports:
//   clk_50MHz     in   system clock
//   rst           in   asynchronous reset, active-high
//   tx_data[7:0]  in   command byte
//   tx_valid      in   request, accepted when tx_valid & tx_ready
//   tx_ready      out  high only in IDLE
//   PS2Clk_in     in   PS2Clk pad (async)
//   PS2Data_in    in   PS2Data pad (async)
//   ps2_clk_low   out  1 = pull PS2Clk low
//   ps2_data_low  out  1 = pull PS2Data low
//   busy          out  frame in flight (state != IDLE)
//   tx_done       out  pulse: frame sent and device ACK = 0
//   tx_ack_err    out  pulse: ACK bit sampled as 1
//   tx_timeout    out  pulse: watchdog expired
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       PS2Clk_in,
  input  logic       PS2Data_in,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);

  localparam logic [12:0] INH_LAST = 13'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] WD_LAST  = 20'(TIMEOUT_CYCLES - 1);

  // Conditioned inputs
  logic        clk_filt_s;
  logic        clk_fall_s;
  logic        data_meta_r;
  logic        data_sync_r;

  // FSM and datapath state
  logic [2:0]  state_r,    state_nxt_s;
  logic [10:0] frame_r,    frame_nxt_s;   // {stop, parity, data[7:0], start}
  logic [3:0]  n_r,        n_nxt_s;
  logic [3:0]  n_inc_s;
  logic [12:0] inh_r,      inh_nxt_s;
  logic [19:0] wd_r,       wd_nxt_s;
  logic        wd_expired_s;

  // Registered outputs
  logic        clk_low_r,  clk_low_nxt_s;
  logic        data_low_r, data_low_nxt_s;
  logic        done_r,     done_nxt_s;
  logic        ack_err_r,  ack_err_nxt_s;
  logic        timeout_r,  timeout_nxt_s;
  logic        tx_ready_r;
  logic        busy_r;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .pad       (PS2Clk_in),
    .filt      (clk_filt_s),
    .fall      (clk_fall_s)
  );

  // PS2Data is only sampled at clock falls, so a plain synchroniser suffices
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      data_meta_r <= PS2Data_in;
      data_sync_r <= data_meta_r;
    end
  end

  assign n_inc_s      = n_r + 4'd1;
  assign wd_expired_s = (wd_r == WD_LAST);

  // Next-state and next-output logic for the transmit FSM
  always_comb begin
    state_nxt_s    = state_r;
    frame_nxt_s    = frame_r;
    n_nxt_s        = n_r;
    inh_nxt_s      = inh_r;
    wd_nxt_s       = wd_r;
    clk_low_nxt_s  = clk_low_r;
    data_low_nxt_s = data_low_r;
    done_nxt_s     = 1'b0;
    ack_err_nxt_s  = 1'b0;
    timeout_nxt_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        clk_low_nxt_s  = 1'b0;
        data_low_nxt_s = 1'b0;
        if (tx_valid) begin
          frame_nxt_s   = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
          n_nxt_s       = 4'd0;
          inh_nxt_s     = 13'd0;
          clk_low_nxt_s = 1'b1;
          state_nxt_s   = ST_INHIBIT;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end

      ST_INHIBIT: begin
        if (inh_r == INH_LAST) begin
          // Start bit goes out together with the last cycle of clock hold
          data_low_nxt_s = ~frame_r[0];
          state_nxt_s    = ST_RTS;
        end else begin
          inh_nxt_s      = inh_r + 13'd1;
        end
      end

      ST_RTS: begin
        clk_low_nxt_s = 1'b0;
        wd_nxt_s      = 20'd0;
        n_nxt_s       = 4'd0;
        state_nxt_s   = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (wd_expired_s) begin
          clk_low_nxt_s  = 1'b0;
          data_low_nxt_s = 1'b0;
          timeout_nxt_s  = 1'b1;
          state_nxt_s    = ST_IDLE;
        end else begin
          wd_nxt_s = wd_r + 20'd1;
          if (clk_fall_s) begin
            if (n_r == LAST_BIT) begin
              // Stop bit already on the line; this fall starts the ACK slot
              state_nxt_s    = ST_ACK;
            end else begin
              n_nxt_s        = n_inc_s;
              data_low_nxt_s = ~frame_r[n_inc_s];
            end
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end
      end

      ST_ACK: begin
        data_low_nxt_s = 1'b0;
        // Timeout has priority over an ACK sampled in the same cycle
        if (wd_expired_s) begin
          clk_low_nxt_s = 1'b0;
          timeout_nxt_s = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          wd_nxt_s = wd_r + 20'd1;
          if (clk_fall_s) begin
            if (data_sync_r == 1'b0) begin
              state_nxt_s   = ST_WAIT_IDLE;
            end else begin
              ack_err_nxt_s = 1'b1;
              state_nxt_s   = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_ACK;
          end
        end
      end

      ST_WAIT_IDLE: begin
        data_low_nxt_s = 1'b0;
        if (wd_expired_s) begin
          clk_low_nxt_s = 1'b0;
          timeout_nxt_s = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          wd_nxt_s = wd_r + 20'd1;
          if (clk_filt_s && data_sync_r) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_WAIT_IDLE;
          end
        end
      end

      default: begin
        clk_low_nxt_s  = 1'b0;
        data_low_nxt_s = 1'b0;
        state_nxt_s    = ST_IDLE;
      end
    endcase
  end

  // FSM, counters, frame and output registers
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      frame_r    <= 11'd0;
      n_r        <= 4'd0;
      inh_r      <= 13'd0;
      wd_r       <= 20'd0;
      clk_low_r  <= 1'b0;
      data_low_r <= 1'b0;
      done_r     <= 1'b0;
      ack_err_r  <= 1'b0;
      timeout_r  <= 1'b0;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      frame_r    <= frame_nxt_s;
      n_r        <= n_nxt_s;
      inh_r      <= inh_nxt_s;
      wd_r       <= wd_nxt_s;
      clk_low_r  <= clk_low_nxt_s;
      data_low_r <= data_low_nxt_s;
      done_r     <= done_nxt_s;
      ack_err_r  <= ack_err_nxt_s;
      timeout_r  <= timeout_nxt_s;
      tx_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  assign tx_ready     = tx_ready_r;
  assign busy         = busy_r;
  assign ps2_clk_low  = clk_low_r;
  assign ps2_data_low = data_low_r;
  assign tx_done      = done_r;
  assign tx_ack_err   = ack_err_r;
  assign tx_timeout   = timeout_r;

endmodule
